cw_port_arbiter: RTL

Output-port controller for the clockwise ring link of a router node. Each cycle it arbitrates the clockwise output between two requesters: the clockwise input buffer forwarding through-traffic, and the PE injection buffer. It owns the even/odd polarity phase that the node's input buffers use, issues the per-requester write enables, and registers the winning flit onto the link.

---
 rtl/cw_port_arbiter_pkg.sv | 14 +
 rtl/cw_port_arbiter_rr_arb2.sv | 50 +++++
 rtl/cw_port_arbiter.sv | 63 ++++++
 3 files changed

// File: rtl/cw_port_arbiter_pkg.sv
// Shared constants for the clockwise output-port arbiter.
package cw_port_arbiter_pkg;
  // Virtual-channel identifiers; the current VC equals the polarity bit.
  localparam logic VC_EVEN = 1'b0;
  localparam logic VC_ODD  = 1'b1;

  // Arbitration modes.
  localparam int ARB_RR   = 0;  // round-robin per VC
  localparam int ARB_RING = 1;  // through-traffic first, with starvation escape

  // Default flit width and the routing-bit position inside a flit.
  localparam int DW_DEF    = 64;
  localparam int ROUTE_BIT = 48;
endpackage

// File: rtl/cw_port_arbiter_rr_arb2.sv
// Two-input arbiter for one VC. It holds that VC's round-robin pointer and
// starvation counter. Grants are combinational. State moves only while this
// VC is the current phase.
module rr_arb2
  import cw_port_arbiter_pkg::*;
#(
  parameter int ARB_MODE   = ARB_RR,
  parameter int STARVE_MAX = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic active,
  input  logic req_cw,
  input  logic req_pe,
  input  logic cwro,
  output logic gnt_cw,
  output logic gnt_pe
);
  localparam logic [3:0] SMAX = 4'(STARVE_MAX);

  logic       ptr;     // 0 favours cw, 1 favours pe
  logic [3:0] starve;  // consecutive PE losses on this VC
  logic       pe_tie;  // pe wins when both requesters are asserted

  // Tie-break and grants. Both grants are held low while reset is asserted.
  always_comb begin
    pe_tie = (ARB_MODE == ARB_RR) ? ptr : (starve == SMAX);
    gnt_cw = reset & cwro & req_cw & (~req_pe | ~pe_tie);
    gnt_pe = reset & cwro & req_pe & (~req_cw |  pe_tie);
  end

  // Pointer and counter update. A cycle with cwro low is backpressure, not a
  // loss, so it leaves all state unchanged.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr    <= 1'b0;
      starve <= '0;
    end else if (active && cwro) begin
      // Favour whichever side did not win. An uncontested grant follows the same rule.
      if (ARB_MODE == ARB_RR && (gnt_cw || gnt_pe))
        ptr <= gnt_cw;
      if (ARB_MODE == ARB_RING) begin
        if (gnt_pe)
          starve <= '0;
        else if (req_pe && starve != SMAX)
          starve <= starve + 4'd1;
      end
    end
  end
endmodule

// File: rtl/cw_port_arbiter.sv
// Clockwise ring-link output controller. It owns the even/odd phase bit and
// arbitrates through-traffic against PE injection on the current phase's VC.
// It registers the winning flit onto the link.
module cw_port_arbiter
  import cw_port_arbiter_pkg::*;
#(
  parameter int DW         = DW_DEF,
  parameter int ARB_MODE   = ARB_RR,
  parameter int STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req_cw,
  input  logic [DW-1:0] data_cw,
  input  logic          req_pe,
  input  logic [DW-1:0] data_pe,
  input  logic          cwro,
  output logic          gnt_cw,
  output logic          gnt_pe,
  output logic          polarity,
  output logic          cwso,
  output logic [DW-1:0] cwdo,
  output logic          cwdo_vc
);
  logic [1:0] vgnt_cw, vgnt_pe;

  // One arbiter per VC. Only the instance matching the current phase is active.
  for (genvar v = 0; v < 2; v++) begin : g_vc
    rr_arb2 #(.ARB_MODE(ARB_MODE), .STARVE_MAX(STARVE_MAX)) u_arb (
      .clk    (clk),
      .reset  (reset),
      .active (polarity == ((v == 0) ? VC_EVEN : VC_ODD)),
      .req_cw (req_cw),
      .req_pe (req_pe),
      .cwro   (cwro),
      .gnt_cw (vgnt_cw[v]),
      .gnt_pe (vgnt_pe[v])
    );
  end

  // The current phase selects which VC's grants reach the requesters.
  always_comb begin
    gnt_cw = vgnt_cw[polarity];
    gnt_pe = vgnt_pe[polarity];
  end

  // Phase toggle and link register. An in-flight flit is dropped on reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      polarity <= VC_EVEN;
      cwso     <= 1'b0;
      cwdo     <= '0;
      cwdo_vc  <= VC_EVEN;
    end else begin
      polarity <= ~polarity;
      cwso     <= gnt_cw | gnt_pe;
      if (gnt_cw || gnt_pe) begin
        cwdo    <= gnt_pe ? data_pe : data_cw;
        cwdo_vc <= polarity;
      end
    end
  end
endmodule
